tx_stats_collector: RTL and testbench

Monitors the 64-bit XGMII transmit stream in the `clk_xgmii_tx` domain and measures each frame's length in octets, from destination address through FCS. After each cleanly terminated frame it issues one single-cycle write of the octet count. That write drives `txsfifo_wen` / `txsfifo_wdata` of the TX statistics FIFO, which carries the count into the Wishbone domain for packet and octet accumulation. Frames ended by an error are not reported.

---
 rtl/tx_stats_collector.sv | 129 ++++++++++++
 tb/tb_tx_stats_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_stats_collector.sv
// tx_stats_collector
//   Watches the 64-bit XGMII transmit stream and measures each frame's length
//   in octets (destination address through FCS). After every frame that ends
//   cleanly with /T/, it issues one single-cycle write of the octet count to the
//   TX statistics FIFO. Frames that end with any other control character are
//   dropped silently.
//
// Ports
//   clk_xgmii_tx      XGMII TX clock (only clock)
//   reset_xgmii_tx_n  asynchronous active-low reset
//   xgmii_txd[63:0]   TX data, lane k = bits [8k+7:8k], lane 0 first on the wire
//   xgmii_txc[7:0]    TX control, bit k marks lane k as a control character
//   txsfifo_wen       one-cycle write strobe to the TX stats FIFO
//   txsfifo_wdata     frame octet count, saturated at 16383; holds between writes
module tx_stats_collector (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx_n,
  input  logic [63:0] xgmii_txd,
  input  logic [7:0]  xgmii_txc,
  output logic        txsfifo_wen,
  output logic [13:0] txsfifo_wdata
);

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;

  typedef enum logic [1:0] {
    IDLE,
    PRE_HALF,
    DATA
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic        wen_d;
  logic [13:0] wdata_d;

  logic [7:0]  ctl_vec;
  logic        ctl_found;
  logic [2:0]  ctl_lane;
  logic [7:0]  ctl_char;
  logic [14:0] sum_term;
  logic [14:0] sum_data;
  logic [13:0] sat_term;
  logic [13:0] sat_data;

  // Lowest control lane in the column. In the column after a lane-4 start,
  // lanes 0-3 carry preamble/SFD and are masked out of the search.
  always_comb begin
    ctl_vec   = (state_q == PRE_HALF) ? {xgmii_txc[7:4], 4'b0000} : xgmii_txc;
    ctl_found = 1'b0;
    ctl_lane  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!ctl_found && ctl_vec[i]) begin
        ctl_found = 1'b1;
        ctl_lane  = 3'(i);
      end
    end
    ctl_char = xgmii_txd[{ctl_lane, 3'b000} +: 8];
  end

  // 15-bit sums clamp to 14 bits; a saturated count therefore stays pinned.
  always_comb begin
    sum_term = {1'b0, cnt_q} + {12'b0, ctl_lane};
    sum_data = {1'b0, cnt_q} + 15'd8;
    sat_term = sum_term[14] ? '1 : sum_term[13:0];
    sat_data = sum_data[14] ? '1 : sum_data[13:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    wdata_d = txsfifo_wdata;
    unique case (state_q)
      IDLE: begin
        if (xgmii_txc[0] && xgmii_txd[7:0] == CH_START) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (xgmii_txc[4] && xgmii_txd[39:32] == CH_START &&
                     xgmii_txc[3:0] == 4'hF) begin
          state_d = PRE_HALF;
          cnt_d   = '0;
        end
      end
      PRE_HALF: begin
        if (!ctl_found) begin
          state_d = DATA;
          cnt_d   = 14'd4;
        end else begin
          state_d = IDLE;
          if (ctl_char == CH_TERM) begin
            wen_d   = 1'b1;
            wdata_d = {11'b0, ctl_lane} - 14'd4;
          end
        end
      end
      DATA: begin
        if (!ctl_found) begin
          cnt_d = sat_data;
        end else begin
          // Any non-/T/ control (including /S/) aborts; a new frame must
          // start from IDLE on a later column.
          state_d = IDLE;
          if (ctl_char == CH_TERM) begin
            wen_d   = 1'b1;
            wdata_d = sat_term;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      txsfifo_wen   <= 1'b0;
      txsfifo_wdata <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      txsfifo_wen   <= wen_d;
      txsfifo_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_tx_stats_collector.sv
module tb_tx_stats_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        wen;
  logic [13:0] wdata;

  tx_stats_collector dut (
    .clk_xgmii_tx     (clk),
    .reset_xgmii_tx_n (rst_n),
    .xgmii_txd        (txd),
    .xgmii_txc        (txc),
    .txsfifo_wen      (wen),
    .txsfifo_wdata    (wdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [13:0] cnt;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          lane4;
    int unsigned n;
    int unsigned t_lane;
    bit          pre_t;
    bit          err;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    txd = d;
    txc = c;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(64'h0707070707070707, 8'hFF);
  endtask

  // Ending column: random data below `lane`, control `ch` at `lane`, idle above.
  task automatic term_col(input int unsigned lane, input logic [7:0] ch,
                          input bit do_push, input logic [13:0] exp);
    logic [63:0] d;
    logic [7:0]  c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < lane) begin
        d[8*i +: 8] = 8'($urandom);
        c[i] = 1'b0;
      end else if (i == lane) begin
        d[8*i +: 8] = ch;
        c[i] = 1'b1;
      end else begin
        d[8*i +: 8] = 8'h07;
        c[i] = 1'b1;
      end
    end
    @(negedge clk);
    txd = d;
    txc = c;
    if (do_push) sb.push_back('{cnt: exp, cyc: cyc + 1});
  endtask

  task automatic send_frame(input bit lane4, input int unsigned n, input int unsigned t_lane,
                            input bit pre_t, input bit err, input logic [13:0] exp);
    if (!lane4) begin
      drive(64'hD5555555555555FB, 8'h01);
    end else begin
      drive(64'hD55555FB07070707, 8'h1F);
      if (pre_t) begin
        term_col(t_lane, err ? 8'hFE : 8'hFD, !err, exp);
        return;
      end
      drive(64'hD555555555555555, 8'h00);
    end
    repeat (n) drive({$urandom, $urandom}, 8'h00);
    term_col(t_lane, err ? 8'hFE : 8'hFD, !err, exp);
  endtask

  task automatic monitor();
    logic        prev_wen = 1'b0;
    logic [13:0] hold = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = '0;
        prev_wen = 1'b0;
      end else if (wen) begin
        chk("wen_not_consecutive", {31'b0, prev_wen}, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_wen: wdata=%0d with no frame expected (cycle %0d)", wdata, cyc);
        end else begin
          e = sb.pop_front();
          chk("wdata", {18'b0, wdata}, {18'b0, e.cnt});
          chk("write_latency_cycle", cyc, e.cyc);
        end
        hold = wdata;
        prev_wen = 1'b1;
      end else begin
        chk("wdata_hold", {18'b0, wdata}, {18'b0, hold});
        prev_wen = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txd = 64'h0707070707070707;
    txc = 8'hFF;
    fork
      monitor();
    join_none

    tbl[0] = '{1'b0, 8, 0, 1'b0, 1'b0, 14'd64};
    tbl[1] = '{1'b1, 7, 0, 1'b0, 1'b0, 14'd60};
    tbl[2] = '{1'b1, 0, 5, 1'b1, 1'b0, 14'd1};
    tbl[3] = '{1'b0, 8, 5, 1'b0, 1'b0, 14'd69};
    tbl[4] = '{1'b0, 3, 2, 1'b0, 1'b1, 14'd0};
    tbl[5] = '{1'b0, 8, 0, 1'b0, 1'b0, 14'd64};
    tbl[6] = '{1'b0, 0, 7, 1'b0, 1'b0, 14'd7};
    tbl[7] = '{1'b1, 0, 4, 1'b0, 1'b0, 14'd8};
    tbl[8] = '{1'b1, 0, 6, 1'b1, 1'b1, 14'd0};
    tbl[9] = '{1'b0, 1, 0, 1'b0, 1'b0, 14'd8};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_wen", {31'b0, wen}, 0);
    chk("reset_wdata", {18'b0, wdata}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      send_frame(tbl[i].lane4, tbl[i].n, tbl[i].t_lane, tbl[i].pre_t, tbl[i].err, tbl[i].exp);
      idle(3);
      chk($sformatf("drain_vec%0d", i), sb.size(), 0);
    end

    // Back-to-back: lane-0 /S/ immediately after the /T/ column
    send_frame(1'b0, 8, 5, 1'b0, 1'b0, 14'd69);
    send_frame(1'b0, 8, 0, 1'b0, 1'b0, 14'd64);
    idle(3);
    chk("drain_back_to_back", sb.size(), 0);

    // Abort with /S/ in the aborting column: following data and /T/ not counted
    drive(64'hD5555555555555FB, 8'h01);
    repeat (2) drive({$urandom, $urandom}, 8'h00);
    term_col(3, 8'hFB, 1'b0, 14'd0);
    drive({$urandom, $urandom}, 8'h00);
    term_col(0, 8'hFD, 1'b0, 14'd0);
    idle(3);
    chk("drain_abort_start", sb.size(), 0);

    // Saturation
    send_frame(1'b0, 2100, 3, 1'b0, 1'b0, 14'd16383);
    idle(3);
    chk("drain_saturation", sb.size(), 0);

    // Asynchronous reset mid-frame (wdata currently 16383)
    drive(64'hD5555555555555FB, 8'h01);
    repeat (3) drive({$urandom, $urandom}, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_wen", {31'b0, wen}, 0);
    chk("async_reset_wdata", {18'b0, wdata}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) drive({$urandom, $urandom}, 8'h00);
    term_col(2, 8'hFD, 1'b0, 14'd0);
    idle(3);
    chk("drain_after_reset", sb.size(), 0);
    send_frame(1'b0, 2, 4, 1'b0, 1'b0, 14'd20);
    idle(3);
    chk("drain_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
